// File: rtl/subsurf_pkg.sv
// Shared quadram constants and requester indices for the subsurf RAM datapath.
// The arbiter and picker draw their defaults and the index-wrap helper from here.
package subsurf_pkg;

  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  localparam int REQ_SPI_IN  = 0;
  localparam int REQ_SUBSURF = 1;
  localparam int REQ_SPI_OUT = 2;

  // Circular successor of a requester index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/quadram_arbiter_rr_pick.sv
// Combinational circular priority picker: first request at or after rr_ptr wins.
// Produces the winner as one-hot, as an index and as an any-request flag.
module rr_pick
  import subsurf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  always_comb begin
    int pos;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    pos    = int'(rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[pos]) begin
        onehot[pos] = 1'b1;
        index       = IDX_W'(pos);
        any         = 1'b1;
      end
      pos = wrap_inc(pos, NUM_REQ);
    end
  end

endmodule

// File: rtl/quadram_arbiter.sv
// Shares one synchronous-read quadram port between NUM_REQ requesters with round-robin
// arbitration, bounded locked bursts and per-requester read-data-valid tagging.
module quadram_arbiter
  import subsurf_pkg::wrap_inc;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = subsurf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = subsurf_pkg::DATA_WIDTH,
  parameter int MAX_BURST  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             ram_en,
  output logic [(DATA_WIDTH/8)-1:0]        ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_din,
  input  logic [DATA_WIDTH-1:0]            ram_dout
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
    $error("quadram_arbiter: NUM_REQ must be in 2..8");
  end

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic               owner_vld;
  logic [CNT_W-1:0]   burst_cnt;
  logic [NUM_REQ-1:0] tag_p1;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               others_pending;
  logic               forced;
  logic               keep;
  logic               accept;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic [BE_W-1:0]    win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_din;
  logic [NUM_REQ-1:0] rd_acc;

  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] din_hold;

  // Owner keeps the port unless it has used its burst budget and someone else waits.
  always_comb begin
    owner_mask     = owner_vld ? (NUM_REQ'(1) << owner) : '0;
    owner_req      = |(req & owner_mask);
    others_pending = |(req & ~owner_mask);
    forced         = owner_req && (burst_cnt == CNT_LAST) && others_pending;
    keep           = owner_req && !forced;
    pick_req       = forced ? (req & ~owner_mask) : req;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (pick_req),
    .rr_ptr (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    accept     = !reset && (keep || pick_any);
    win_idx    = keep ? owner : pick_idx;
    win_onehot = '0;
    if (accept) win_onehot = keep ? owner_mask : pick_onehot;
    win_we     = we[int'(win_idx)*BE_W +: BE_W];
    win_addr   = addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_din    = wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    rd_acc     = win_onehot & {NUM_REQ{win_we == '0}};
  end

  // Address and write data park on the last granted values while the port idles.
  always_comb begin
    gnt      = win_onehot;
    ram_en   = accept;
    ram_we   = accept ? win_we : '0;
    ram_addr = accept ? win_addr : addr_hold;
    ram_din  = accept ? win_din : din_hold;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_hold <= win_addr;
      din_hold  <= win_din;
    end
  end

  // Stage p0 -> p1: arbitration state and read tag, aligned with the RAM's read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      burst_cnt <= '0;
      tag_p1    <= '0;
    end else begin
      tag_p1 <= rd_acc;
      if (accept) begin
        rr_ptr <= IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));
        if (lock[win_idx]) begin
          owner_vld <= 1'b1;
          owner     <= win_idx;
          if (owner_vld && owner == win_idx)
            burst_cnt <= (burst_cnt == CNT_LAST) ? burst_cnt : burst_cnt + 1'b1;
          else
            burst_cnt <= '0;
        end else begin
          owner_vld <= 1'b0;
          burst_cnt <= '0;
        end
      end else if (owner_vld) begin
        owner_vld <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

  assign rvalid = tag_p1;
  assign rdata  = ram_dout;

  a_ptr_range: assert property (@(posedge clk) disable iff (reset)
    int'(rr_ptr) < NUM_REQ);
  a_owner_range: assert property (@(posedge clk) disable iff (reset)
    !owner_vld || int'(owner) < NUM_REQ);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt) && ((gnt & ~req) == '0));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(rvalid));

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_contract
    a_payload_hold: assert property (@(posedge clk) disable iff (reset)
      (req[i] && !gnt[i]) |=> (!req[i] ||
        ($stable(we[i*BE_W +: BE_W]) &&
         $stable(addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
         $stable(wdata[i*DATA_WIDTH +: DATA_WIDTH]))));
  end

endmodule
